// File: rtl/servio_pkg.sv
// Shared constants and state encoding for the servio cycle-code scheduler.
package servio_pkg;

  localparam int unsigned NumHarts = 4;
  localparam int unsigned ByteW    = 2;

  localparam logic [5:0] CYC_IDLE_GAP = 6'h10;
  localparam logic [5:0] CYC_IDLE_DIS = 6'h20;

  typedef enum logic [1:0] {StStop, StSlot, StGap, StArb} sched_state_e;

endpackage

// File: rtl/servio_rr_pick.sv
// Combinational 4-way circular priority picker: first eligible hart after pointer.
module servio_rr_pick
  import servio_pkg::*;
(
  input  logic [NumHarts-1:0] eligible,
  input  logic [1:0]          pointer,
  output logic                found,
  output logic [1:0]          winner
);

  logic [1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = pointer;
    idx    = pointer;
    // i == NumHarts wraps back to the pointer itself, so it has lowest priority.
    for (int i = 1; i <= int'(NumHarts); i++) begin
      idx = pointer + 2'(i);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/servio_slot_sched.sv
// Cycle-code generator for a four-hart byte-serial ROM mux: fixed TDM frames or
// work-conserving round-robin slots driven by the harts' bus requests.
module servio_slot_sched
  import servio_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 48,
  parameter int unsigned COOLDOWN   = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                cfg_mode,
  input  logic [NumHarts-1:0] cfg_en,
  input  logic [NumHarts-1:0] wb_cyc,
  output logic [5:0]          aso_cyc_data,
  output logic                aso_cyc_valid,
  output logic [NumHarts-1:0] grant,
  output logic                sof,
  output logic [CNT_W-1:0]    slot_cnt
);

  localparam int unsigned CoolW   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);

  sched_state_e state_q, state_d;
  logic                             mode_q, mode_d;
  logic [1:0]                       hart_q, hart_d;
  logic [ByteW-1:0]                 byte_q, byte_d;
  logic                             slot_en_q, slot_en_d;
  logic [15:0]                      gap_q, gap_d;
  logic [1:0]                       ptr_q, ptr_d;
  logic [NumHarts-1:0][CoolW-1:0]   cool_q, cool_d;
  logic [NumHarts-1:0]              cooling, eligible;
  logic                             found, go_fixed, go_rr, slot_end;
  logic [1:0]                       winner, hart_inc;
  logic [5:0]                       data_d;
  logic [NumHarts-1:0]              grant_d;
  logic [CNT_W-1:0]                 cnt_d;

  assign slot_end = (state_q == StSlot) && (byte_q == 2'd3);
  assign hart_inc = hart_q + 2'd1;

  // Cooling is judged on the counter value for the cycle being decided, so a
  // hart finishing its slot can never take the very next slot.
  always_comb begin
    for (int n = 0; n < int'(NumHarts); n++) begin
      if (slot_end && hart_q == 2'(n)) cool_d[n] = CoolW'(COOLDOWN);
      else if (cool_q[n] != '0)         cool_d[n] = cool_q[n] - CoolW'(1);
      else                              cool_d[n] = '0;
      cooling[n] = (cool_d[n] != '0);
    end
  end

  assign eligible = cfg_en & wb_cyc & ~cooling;

  servio_rr_pick u_pick (
    .eligible (eligible),
    .pointer  (ptr_q),
    .found    (found),
    .winner   (winner)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    hart_d    = hart_q;
    byte_d    = byte_q;
    slot_en_d = slot_en_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    go_fixed  = 1'b0;
    go_rr     = 1'b0;
    unique case (state_q)
      StStop: begin
        go_fixed = run & ~cfg_mode;
        go_rr    = run & cfg_mode;
      end
      StSlot: begin
        if (byte_q != 2'd3) begin
          byte_d = byte_q + 2'd1;
        end else if (!run) begin
          state_d = StStop;
        end else if (mode_q) begin
          go_fixed = ~cfg_mode;
          go_rr    = cfg_mode;
        end else if (hart_q != 2'd3) begin
          hart_d    = hart_inc;
          byte_d    = '0;
          slot_en_d = cfg_en[hart_inc];
        end else if (GAP_CYCLES != 0) begin
          state_d = StGap;
          gap_d   = '0;
        end else begin
          go_fixed = ~cfg_mode;
          go_rr    = cfg_mode;
        end
      end
      StGap: begin
        if (!run) begin
          state_d = StStop;
        end else if (gap_q == GapLast) begin
          go_fixed = ~cfg_mode;
          go_rr    = cfg_mode;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      StArb: begin
        if (!run) state_d = StStop;
        else begin
          go_fixed = ~cfg_mode;
          go_rr    = cfg_mode;
        end
      end
      default: state_d = StStop;
    endcase

    if (go_fixed) begin
      state_d   = StSlot;
      mode_d    = 1'b0;
      hart_d    = '0;
      byte_d    = '0;
      slot_en_d = cfg_en[0];
    end
    if (go_rr) begin
      mode_d = 1'b1;
      if (found) begin
        state_d   = StSlot;
        hart_d    = winner;
        byte_d    = '0;
        slot_en_d = 1'b1;
        ptr_d     = winner;
      end else begin
        state_d = StArb;
      end
    end
  end

  always_comb begin
    data_d  = '0;
    grant_d = '0;
    unique case (state_d)
      StSlot: begin
        if (slot_en_d) begin
          data_d  = {2'b00, hart_d, byte_d};
          grant_d = 4'b0001 << hart_d;
        end else begin
          data_d = CYC_IDLE_DIS | {4'b0000, byte_d};
        end
      end
      StGap, StArb: data_d = CYC_IDLE_GAP;
      default: data_d = '0;
    endcase
    cnt_d = slot_cnt + CNT_W'(slot_end && slot_en_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StStop;
      mode_q        <= 1'b0;
      hart_q        <= '0;
      byte_q        <= '0;
      slot_en_q     <= 1'b0;
      gap_q         <= '0;
      ptr_q         <= 2'd3;
      cool_q        <= '0;
      aso_cyc_data  <= '0;
      aso_cyc_valid <= 1'b0;
      grant         <= '0;
      sof           <= 1'b0;
      slot_cnt      <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      hart_q        <= hart_d;
      byte_q        <= byte_d;
      slot_en_q     <= slot_en_d;
      gap_q         <= gap_d;
      ptr_q         <= ptr_d;
      cool_q        <= cool_d;
      aso_cyc_data  <= data_d;
      aso_cyc_valid <= (state_d != StStop);
      grant         <= grant_d;
      sof           <= go_fixed;
      slot_cnt      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_servio_slot_sched.sv
// Directed, table-driven bench for servio_slot_sched (GAP_CYCLES=48, COOLDOWN=2).
module tb_servio_slot_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [3:0]  cfg_en = 4'hF;
  logic [3:0]  wb_cyc = 4'h0;
  logic [5:0]  aso_cyc_data;
  logic        aso_cyc_valid;
  logic [3:0]  grant;
  logic        sof;
  logic [15:0] slot_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  servio_slot_sched #(
    .GAP_CYCLES (48),
    .COOLDOWN   (2),
    .CNT_W      (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .cfg_mode      (cfg_mode),
    .cfg_en        (cfg_en),
    .wb_cyc        (wb_cyc),
    .aso_cyc_data  (aso_cyc_data),
    .aso_cyc_valid (aso_cyc_valid),
    .grant         (grant),
    .sof           (sof),
    .slot_cnt      (slot_cnt)
  );

  typedef struct {
    bit         rst;
    logic       run;
    logic       mode;
    logic [3:0] en;
    logic [3:0] cyc;
    logic       v;
    logic [5:0] data;
    logic [3:0] grant;
    logic       sof;
    bit         chk_cnt;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic r, logic m, logic [3:0] en, logic [3:0] cyc,
                              logic v, logic [5:0] d, logic [3:0] g, logic s,
                              bit cc, logic [15:0] cnt);
    vec_t x;
    x.rst = rst; x.run = r; x.mode = m; x.en = en; x.cyc = cyc;
    x.v = v; x.data = d; x.grant = g; x.sof = s; x.chk_cnt = cc; x.cnt = cnt;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    run      = 1'b0;
    cfg_mode = 1'b0;
    cfg_en   = 4'hF;
    wb_cyc   = 4'h0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int k;

    // RR, only hart 2 requesting: two idle cycles between its slots.
    vecs.push_back(mk(1, 1, 1, 4'hF, 4'h4, 1, 6'h08, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h4, 1, 6'h09, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h4, 1, 6'h0A, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h4, 1, 6'h0B, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h4, 1, 6'h10, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h4, 1, 6'h10, 4'h0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h4, 1, 6'h08, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h4, 1, 6'h09, 4'h4, 0, 0, 0));
    // RR, harts 0 and 3 requesting: alternate with no idle, hart 0 first.
    vecs.push_back(mk(1, 1, 1, 4'hF, 4'h9, 1, 6'h00, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h9, 1, 6'h01, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h9, 1, 6'h02, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h9, 1, 6'h03, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h9, 1, 6'h0C, 4'h8, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h9, 1, 6'h0D, 4'h8, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h9, 1, 6'h0E, 4'h8, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h9, 1, 6'h0F, 4'h8, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h9, 1, 6'h00, 4'h1, 0, 0, 0));
    // RR, run dropped during byte 1 of a hart 1 slot.
    vecs.push_back(mk(1, 1, 1, 4'hF, 4'h2, 1, 6'h04, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'h2, 1, 6'h05, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'hF, 4'h2, 1, 6'h06, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'hF, 4'h2, 1, 6'h07, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'hF, 4'h2, 0, 6'h00, 4'h0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 4'hF, 4'h2, 0, 6'h00, 4'h0, 0, 1, 1));
    // Fixed, cfg_en=1010: disabled slots keep timing but emit idle codes.
    vecs.push_back(mk(1, 1, 0, 4'hA, 4'h0, 1, 6'h20, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h21, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h22, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h23, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h04, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h05, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h06, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h07, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h20, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h21, 4'h0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h22, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h23, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h0C, 4'h8, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h0D, 4'h8, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h0E, 4'h8, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h0F, 4'h8, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h10, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1, 6'h10, 4'h0, 0, 1, 2));
    // RR -> fixed: mode change honoured only at the slot boundary.
    vecs.push_back(mk(1, 1, 1, 4'hF, 4'h4, 1, 6'h08, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hF, 4'h4, 1, 6'h09, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hF, 4'h4, 1, 6'h0A, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hF, 4'h4, 1, 6'h0B, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hF, 4'h4, 1, 6'h00, 4'h1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hF, 4'h4, 1, 6'h01, 4'h1, 0, 0, 0));

    // Reset state.
    do_reset();
    check("reset valid", aso_cyc_valid, 0);
    check("reset data", aso_cyc_data, 6'h00);
    check("reset grant", grant, 0);
    check("reset sof", sof, 0);
    check("reset cnt", slot_cnt, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      run      = vecs[i].run;
      cfg_mode = vecs[i].mode;
      cfg_en   = vecs[i].en;
      wb_cyc   = vecs[i].cyc;
      step();
      check($sformatf("row%0d valid", i), aso_cyc_valid, vecs[i].v);
      check($sformatf("row%0d data", i), aso_cyc_data, vecs[i].data);
      check($sformatf("row%0d grant", i), grant, vecs[i].grant);
      check($sformatf("row%0d sof", i), sof, vecs[i].sof);
      if (vecs[i].chk_cnt) check($sformatf("row%0d cnt", i), slot_cnt, vecs[i].cnt);
    end

    // Fixed, all enabled: 16 slot codes + 48 gap codes, then the frame repeats.
    do_reset();
    run = 1'b1;
    cfg_mode = 1'b0;
    cfg_en = 4'hF;
    for (int i = 0; i < 65; i++) begin
      step();
      k = i % 64;
      check($sformatf("frame c%0d valid", i), aso_cyc_valid, 1);
      check($sformatf("frame c%0d data", i), aso_cyc_data, (k < 16) ? k : 6'h10);
      check($sformatf("frame c%0d grant", i), grant, (k < 16) ? (4'b0001 << (k / 4)) : 4'h0);
      check($sformatf("frame c%0d sof", i), sof, (k == 0) ? 1 : 0);
      if (i == 63) check("frame cnt", slot_cnt, 4);
    end

    // Asynchronous reset mid-slot, then first RR tie goes to hart 0.
    do_reset();
    run = 1'b1;
    cfg_mode = 1'b1;
    wb_cyc = 4'h9;
    repeat (6) step();
    check("pre-reset data", aso_cyc_data, 6'h0D);
    check("pre-reset cnt", slot_cnt, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async valid", aso_cyc_valid, 0);
    check("async data", aso_cyc_data, 6'h00);
    check("async grant", grant, 0);
    check("async cnt", slot_cnt, 0);
    #1 reset_n = 1'b1;
    step();
    check("post-reset data", aso_cyc_data, 6'h00);
    check("post-reset grant", grant, 4'h1);
    check("post-reset valid", aso_cyc_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servio_slot_sched.md
Name: servio_slot_sched

Overview:
- Generates the 6-bit cycle-code stream (`aso_cyc_data`/`aso_cyc_valid`) that drives the four-hart byte-serial instruction ROM multiplexer.
- Code format: bits[3:2] hart select, bits[1:0] byte index, bits[5:4]!=0 means idle.
- Decides which hart owns each 4-cycle slot, in one of two modes:
  - fixed TDM, or
  - work-conserving round-robin driven by the harts' `wb_cyc` requests.
- Sits between the system control logic and the mux; one instance per four-hart cluster.

Parameters:
- `GAP_CYCLES`, 48, idle cycles appended after the 16 slot cycles of each fixed-mode frame (0 allowed).
- `COOLDOWN`, 2, cycles after a hart's byte-3 cycle during which that hart is ineligible in RR mode; covers the ack cycle plus the cyc-drop cycle.
- `CNT_W`, 16, width of the granted-slot statistics counter.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `run`  in  1  enable scheduling; sampled each cycle
- `cfg_mode`  in  1  0 = fixed TDM, 1 = work-conserving RR; sampled only at slot/frame boundaries
- `cfg_en`  in  4  per-hart enable mask
- `wb_cyc`  in  4  hart instruction-bus cyc vector (bit n = hart n)
- `aso_cyc_data`  out  6  cycle code to mux
- `aso_cyc_valid`  out  1  cycle code valid
- `grant`  out  4  one-hot owner of the current slot, 0 when idle
- `sof`  out  1  one-cycle pulse coincident with the first code of a fixed-mode frame
- `slot_cnt`  out  CNT_W  count of granted (non-idle) slots, wraps

Behaviour:
- All outputs are registered.
- Reset values: `aso_cyc_valid`=0, `aso_cyc_data`=6'h00, `grant`=0, `sof`=0, `slot_cnt`=0, state=STOP, RR pointer=3 (hart 0 wins first), cooldown counters=0.
- States:
  - STOP: valid=0, data=0.
  - On `run`=1 go to SLOT (fixed, starting hart 0) or ARB (RR) next cycle. First valid code appears 1 cycle after `run` is sampled high.
- Fixed mode (`cfg_mode`=0):
  - Frame = hart 0..3 slots, each bytes 0,1,2,3 (codes 6'h00..6'h0F), then GAP_CYCLES cycles of code 6'h10.
  - Disabled hart (`cfg_en[n]`=0): its 4 cycles emit 6'h20|byte (idle, timing preserved), `grant`=0.
  - `sof`=1 with code 6'h00/6'h20 of hart 0.
  - Frame repeats back-to-back.
- RR mode (`cfg_mode`=1):
  - Evaluated at a slot boundary or each idle cycle.
  - Eligible = `cfg_en` & `wb_cyc` & ~cooling.
  - Winner = first eligible after the RR pointer (circular).
  - Winner found: next 4 cycles emit {2'b00, hart, byte 0..3}; `grant`=one-hot; pointer=winner.
  - None found: emit one cycle of 6'h10, re-evaluate next cycle. No minimum idle length.
  - A slot is never preempted or shortened. `wb_cyc` dropping mid-slot has no effect.
  - `sof` is never asserted.
- Cooldown: the cycle after byte 3 of hart n's slot loads its counter with COOLDOWN. The counter decrements each cycle; hart n is ineligible while it is nonzero.
- `slot_cnt` increments in the byte-3 cycle of every granted slot, in both modes. Wraps at 2^CNT_W.
- `run` falling:
  - Inside a slot (bytes 0..2): finish the slot through byte 3, then go to STOP.
  - In gap or idle: go to STOP on the next cycle.
  - Never emit a partial word.
- `cfg_mode` change: takes effect at the next frame start (fixed→RR) or next slot boundary (RR→fixed; the fixed frame restarts at hart 0).
- `cfg_en` change: sampled at each slot start; a slot in progress completes unchanged.
- Reset is asynchronous. Assertion mid-slot forces all outputs to reset values immediately; there is no completion guarantee.
- Latency: `wb_cyc` rising at an idle RR cycle → byte-0 code for that hart on the next cycle.

Decomposition:
- Shared package `servio_pkg` holds:
  - code constants: `CYC_IDLE_GAP`=6'h10, `CYC_IDLE_DIS`=6'h20, byte-index width 2, hart count 4;
  - the state enum STOP/SLOT/GAP/ARB.
- One sub-module is natural: `servio_rr_pick`, a combinational 4-way circular priority picker taking (eligible[3:0], pointer[1:0]) and returning (found, winner[1:0]).
- Cooldown counters, state machine, and output registers stay in the top module.

Test Plan:
- Fixed mode, `cfg_en`=4'hF, GAP_CYCLES=48, `run`=1 → codes 00..0F then 48×10, repeating. `sof` every 64 cycles. `slot_cnt`=4 after one frame.
- Fixed mode, `cfg_en`=4'b1010 → hart 0 slot codes 20,21,22,23 with `grant`=0. Hart 1 codes 04..07 with `grant`=4'b0010. `slot_cnt` +2 per frame.
- RR mode, `wb_cyc`=4'b1001 held high → alternating hart 0 and hart 3 slots (00..03, 0C..0F). The COOLDOWN gap appears only if a hart is sole eligible. `grant` one-hot matches.
- RR mode, only hart 2 requesting continuously, COOLDOWN=2 → 08,09,0A,0B,10,10,08,… (two idle cycles between slots).
- RR mode, `run` dropped during byte 1 of a hart 1 slot → codes 05 (byte 1), 06, 07 follow, then valid=0, data=0. `slot_cnt` incremented once.
- `reset_n` asserted asynchronously mid-slot → valid=0, data=0, `grant`=0, `slot_cnt`=0 before the next clock edge. After release with `run`=1 in RR mode, hart 0 wins the first tie against hart 3.
